prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader upstream of the miniRISC CPU top. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the word-addressed instruction memory starting at address 0. Holds the CPU in reset until the whole image is written, then releases it.

## Interface
- ADDR_WIDTH, 12: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  write word address.
- imem_wdata  out  32  write data.
- cpu_rst  out  1  reset to CPU top, active-high.
- load_done  out  1  image loaded, CPU running.
- err  out  1  load failed, sticky until rst.

## Operation
- Stream format: N_LO, N_HI (16-bit word count N), then 4·N payload bytes, least-significant byte of each word first; optional checksum byte (see Configuration).
- Byte accepted on a rising edge where rx_valid & rx_ready.
- States: HDR0, HDR1, DATA, CHK, WAIT, RUN, ERROR.
- HDR0: accept N_LO -> HDR1.
- HDR1: accept N_HI. N > 2^ADDR_WIDTH -> ERROR. N = 0 -> CHK if checksum enabled, else RUN. Otherwise -> DATA.
- DATA: 2-bit byte counter; byte k lands in bits [8k+7:8k] of the assembly register. On the 4th byte: load imem_wdata/imem_addr and assert imem_we for the next cycle, increment the word counter, and reset the byte counter. If this was word N, next state is CHK if checksum enabled, else WAIT.
- WAIT: single cycle in which the final imem_we is active; -> RUN.
- CHK: accept checksum byte. Running XOR of all bytes, including header and checksum, equal to 0x00 -> RUN; otherwise -> ERROR.
- RUN: terminal; cpu_rst = 0, load_done = 1, rx_ready = 0; further bytes are ignored.
- ERROR: terminal; cpu_rst = 1, err = 1, rx_ready = 0; no further writes.
- imem_addr increments by 1 per word. Maximum N = 2^ADDR_WIDTH fills memory exactly; the address counter is ADDR_WIDTH+1 bits wide so it never wraps.

## Timing
- Reset values: rx_ready = 0 during rst, then 1 from the first edge after release. imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_rst = 1, load_done = 0, err = 0. State is HDR0 and all counters/XOR are 0.
- rst asserted mid-load asynchronously forces cpu_rst = 1 and the state to HDR0. A partially written image is not erased; a reload overwrites it.
- rx_ready is registered. It is 1 in HDR0/HDR1/DATA/CHK and is never dropped between bytes, so one byte per cycle is sustained.
- Write latency: imem_we is high for exactly the cycle after the 4th byte of a word is accepted. Back-to-back words produce a write every 4 cycles at full rate.
- cpu_rst falls on the edge that ends the final imem_we cycle (no checksum), or on the edge that accepts a matching checksum byte. In both cases this is ≥1 cycle after the last write. load_done rises on the same edge.
- cpu_rst and load_done are registered and glitch-free.

## Configuration
- LOADER_CHKSUM_EN defined: the CHK state exists; one trailing checksum byte is required; a mismatch -> ERROR.
- Not defined: no CHK state, no XOR logic; the last word goes via WAIT to RUN, and err rises only for N > 2^ADDR_WIDTH.

## Test plan
- No checksum: stream 02 00 13 00 00 00 EF BE AD DE at one byte/cycle -> writes addr 0 = 0x00000013 and addr 1 = 0xDEADBEEF. cpu_rst falls one cycle after the second imem_we; load_done = 1.
- Checksum enabled: same stream plus 0x?? chosen so the XOR of all bytes = 0x00 -> RUN. Flip one bit of the checksum byte -> err = 1, cpu_rst stays 1.
- N = 0x1001 with ADDR_WIDTH = 12 -> ERROR after N_HI; no imem_we ever asserted.
- N = 0 -> no writes; RUN directly after N_HI (or after CHK with a 0x00 checksum if enabled).
- rx_valid toggled randomly during a 3-word load -> words and addresses identical to the full-rate case, and bytes are never dropped or duplicated.
- rst pulsed after the 5th payload byte, then a full 1-word stream -> cpu_rst = 1 immediately on rst; addr 0 is rewritten with the new word; normal RUN follows.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader into word-addressed imem.
// Define LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  err
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
`ifdef LOADER_CHKSUM_EN
    CHK,
`endif
    WAIT,
    RUN,
    ERROR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  state_t              state;
  logic [7:0]          n_lo;
  logic [15:0]         n_words;
  logic [1:0]          bcnt;
  logic [ADDR_WIDTH:0] wcnt;
  logic [23:0]         asm_q;
`ifdef LOADER_CHKSUM_EN
  logic [7:0]          xr;
`endif

  logic        acc;
  logic [15:0] n_full;
  logic [31:0] wnext;

  assign acc    = rx_valid & rx_ready;
  assign n_full = {rx_data, n_lo};
  assign wnext  = 32'(wcnt) + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HDR0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      err        <= 1'b0;
      n_lo       <= '0;
      n_words    <= '0;
      bcnt       <= '0;
      wcnt       <= '0;
      asm_q      <= '0;
`ifdef LOADER_CHKSUM_EN
      xr         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      if (acc) xr <= xr ^ rx_data;
`endif
      unique case (state)
        HDR0: begin
          rx_ready <= 1'b1;
          if (acc) begin
            n_lo  <= rx_data;
            state <= HDR1;
          end
        end
        HDR1: begin
          if (acc) begin
            n_words <= n_full;
            if (32'(n_full) > MAX_WORDS) begin
              state    <= ERROR;
              err      <= 1'b1;
              rx_ready <= 1'b0;
            end else if (n_full == 16'd0) begin
`ifdef LOADER_CHKSUM_EN
              state <= CHK;
`else
              state     <= RUN;
              rx_ready  <= 1'b0;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            unique case (bcnt)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              2'd3: begin
                imem_wdata <= {rx_data, asm_q};
                imem_addr  <= wcnt[ADDR_WIDTH-1:0];
                imem_we    <= 1'b1;
                wcnt       <= wcnt + 1'b1;
                if (wnext == 32'(n_words)) begin
`ifdef LOADER_CHKSUM_EN
                  state <= CHK;
`else
                  state    <= WAIT;
                  rx_ready <= 1'b0;
`endif
                end
              end
            endcase
            bcnt <= bcnt + 2'd1;
          end
        end
`ifdef LOADER_CHKSUM_EN
        CHK: begin
          if (acc) begin
            rx_ready <= 1'b0;
            if ((xr ^ rx_data) == 8'h00) begin
              state     <= RUN;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif
        WAIT: begin
          state     <= RUN;
          cpu_rst   <= 1'b0;
          load_done <= 1'b1;
        end
        RUN: begin
          rx_ready <= 1'b0;
        end
        ERROR: begin
          rx_ready <= 1'b0;
          cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader (directed streams).
// Expected imem writes are queued at issue; a negedge monitor checks them.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        err;

  prog_loader #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_we_cyc = 0;
  logic [7:0] xr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_t e;
      n_cmp++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          n_bad++;
          $display("FAIL write: got addr %h data %h, required addr %h data %h",
                   imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    xr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rx_data = b;
    rx_valid = 1'b1;
    xr ^= b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got rx_ready 0, required 1");
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps,
                           input logic [11:0] a);
    exp_q.push_back({a, w});
    for (int k = 0; k < 4; k++) send(w[8*k +: 8], gaps);
  endtask

  task automatic send_chk(input bit corrupt);
`ifdef LOADER_CHKSUM_EN
    logic [7:0] c;
    c = corrupt ? (xr ^ 8'h01) : xr;
    send(c, 1'b0);
`else
    if (corrupt) $display("note: checksum disabled in this build");
`endif
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!load_done && !err && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!load_done && !err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done/err, required one", name);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_err", err, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rx_ready", rx_ready, 1);
    chk("post_rst_cpu_rst", cpu_rst, 1);

    // 2-word image at full rate
    xr = '0;
    send(8'h02, 0);
    send(8'h00, 0);
    send_word(32'h0000_0013, 0, 12'd0);
    send_word(32'hDEAD_BEEF, 0, 12'd1);
    send_chk(0);
    wait_done("two_word");
    chk("two_word_done", load_done, 1);
    chk("two_word_cpu_rst", cpu_rst, 0);
    chk("two_word_err", err, 0);
    chk("two_word_latency", 32'(cyc - last_we_cyc), 1);
    chk("two_word_ready", rx_ready, 0);

    // bytes after RUN are ignored
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_valid = 1'b0;
    chk("run_hold_done", load_done, 1);
    chk("run_hold_ready", rx_ready, 0);

`ifdef LOADER_CHKSUM_EN
    do_reset();
    send(8'h02, 0);
    send(8'h00, 0);
    send_word(32'h0000_0013, 0, 12'd0);
    send_word(32'hDEAD_BEEF, 0, 12'd1);
    send_chk(1);
    wait_done("bad_chk");
    chk("bad_chk_err", err, 1);
    chk("bad_chk_cpu_rst", cpu_rst, 1);
    chk("bad_chk_done", load_done, 0);
`endif

    // N = 0x1001 overflows a 4096-word memory
    do_reset();
    send(8'h01, 0);
    send(8'h10, 0);
    wait_done("too_big");
    chk("too_big_err", err, 1);
    chk("too_big_cpu_rst", cpu_rst, 1);
    chk("too_big_ready", rx_ready, 0);
    chk("too_big_done", load_done, 0);

    // N = 0x1000 is accepted
    do_reset();
    send(8'h00, 0);
    send(8'h10, 0);
    chk("max_n_err", err, 0);
    chk("max_n_ready", rx_ready, 1);

    // N = 0: no writes
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    send_chk(0);
    wait_done("zero");
    chk("zero_done", load_done, 1);
    chk("zero_err", err, 0);
    chk("zero_cpu_rst", cpu_rst, 0);

    // 3 words with random valid gaps
    do_reset();
    send(8'h03, 1);
    send(8'h00, 1);
    send_word(32'h1122_3344, 1, 12'd0);
    send_word(32'hCAFE_F00D, 1, 12'd1);
    send_word(32'h0000_0001, 1, 12'd2);
    send_chk(0);
    wait_done("gaps");
    chk("gaps_done", load_done, 1);
    chk("gaps_err", err, 0);

    // reset mid-load then reload
    do_reset();
    send(8'h02, 0);
    send(8'h00, 0);
    send_word(32'hA5A5_0001, 0, 12'd0);
    send(8'h77, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cpu_rst", cpu_rst, 1);
    chk("mid_rst_ready", rx_ready, 0);
    do_reset();
    send(8'h01, 0);
    send(8'h00, 0);
    send_word(32'h0BAD_F00D, 0, 12'd0);
    send_chk(0);
    wait_done("reload");
    chk("reload_done", load_done, 1);
    chk("reload_cpu_rst", cpu_rst, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
